regfile_multiport: RTL
======================

# regfile_multiport

Parametrised register file that generalises the core's 32×32 two-read/one-write file. It has a configurable data width, depth and read-port count, per-port read enables for pipeline stalls, and optional write-to-read bypass. After every reset a hardware clear sequence zeroes the array and reports completion on `ready`. The block sits in the decode stage of the RISC-V pipeline and feeds operands to execute.

## Interface
Parameters:
- `DW`, default 32: data width in bits.
- `DEPTH`, default 32: number of registers; must be a power of two and ≥ 2.
- `NRD`, default 2: number of read ports, 1..4.
- `ZERO_REG`, default 1: when 1, entry 0 is hardwired to zero and writes to it are dropped.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to a matching read.

Ports (AW = $clog2(DEPTH)):
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `ReadAddr` input NRD×AW: read addresses; port k occupies bits [k*AW +: AW].
- `ReadEn` input NRD: bit k set means port k captures a new value; bit k clear means port k holds its output.
- `ReadData` output NRD×DW: registered read data; port k occupies bits [k*DW +: DW].
- `WriteAddr` input AW: write address.
- `WriteData` input DW: write data.
- `WriteEnable` input 1: write strobe.
- `ready` output 1: high once the clear sequence is complete.

## Operation
- FSM state `CLEAR`:
  - Entered on any cycle where `rst`=1; `rst` sets clear pointer `cptr` to 0.
  - Each cycle with `rst`=0, writes 0 to entry `cptr`, then increments `cptr`.
  - After writing entry DEPTH-1, moves to `RUN`; `cptr` does not wrap.
  - `ready`=0. `WriteEnable` is ignored. `ReadData` ports with `ReadEn` set load 0.
- FSM state `RUN`:
  - `ready`=1.
  - The array is written when `WriteEnable`=1, unless `ZERO_REG`=1 and `WriteAddr`=0.
  - Each port k with `ReadEn[k]`=1 loads `Registers[ReadAddr[k]]` on the clock edge. Ports with `ReadEn[k]`=0 hold their value.
- Bypass, applies only when `BYPASS`=1 in `RUN`: if an accepted write has `WriteAddr`=`ReadAddr[k]` and `ReadEn[k]`=1, port k loads `WriteData` (the new value).
- With `BYPASS`=0, port k in that case loads the pre-write value.
- With `ZERO_REG`=1, a read of address 0 always returns 0, including under bypass.
- All read ports are independent. Any number of ports may address the same entry, with identical results.
- Reset values:
  - `ReadData` = 0 on all ports.
  - `ready` = 0.
  - State = `CLEAR`, `cptr` = 0.
- Array contents are undefined until the clear sequence finishes.
- Reset mid-operation, including mid-`CLEAR`: on the next `rst`=0 cycle, clearing restarts from entry 0.

## Timing
- Read latency is 1 cycle: the address presented at edge n appears on `ReadData` after edge n.
- Write-to-read:
  - A write at edge n is visible to a read issued at edge n+1 regardless of `BYPASS`.
  - It is visible at edge n itself only when `BYPASS`=1.
- Clear duration: `ready` rises after exactly DEPTH clock edges with `rst`=0 following reset deassertion. For DEPTH=32 that is the 32nd edge.
- There is no combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package `regfile_pkg` holds:
  - the state enum `rf_state_t` {`CLEAR`, `RUN`};
  - the function `rf_aw(depth)` returning $clog2(depth).
- Sub-module `regfile_read_port`, instantiated NRD times via generate. Each instance contains:
  - the address mux;
  - the bypass compare;
  - zero-register masking;
  - the hold/enable output register.
- The top level owns the array, the write logic and the clear FSM.

## Test plan
- **Reset/clear:** assert `rst` for 2 cycles, then release (DEPTH=32) → `ready`=0 for 32 edges and 1 after; all reads return 0x00000000. A write of 0xDEAD to entry 5 during `CLEAR` is later read back as 0.
- **Basic write/read:** write 0xA5A5_0001 to entry 7, then read on port 0 the next cycle → 0xA5A50001 one cycle after the read edge; port 1 reading entry 7 simultaneously returns the same value.
- **Bypass:**
  - `BYPASS`=1, write 0x1234 to entry 3 in the same cycle port 1 reads entry 3 → `ReadData` port 1 = 0x1234.
  - Rerun with `BYPASS`=0 → the old value 0x0 is returned.
- **Zero register:** `ZERO_REG`=1, write 0xFFFF_FFFF to entry 0 with a same-cycle read of 0 → both the same-cycle and the later read return 0. With `ZERO_REG`=0 the later read returns 0xFFFFFFFF.
- **Stall hold:** port 0 shows 0x55; drop `ReadEn[0]`, change `ReadAddr` and write that entry → port 0 stays 0x55 until `ReadEn[0]` rises again.
- **Mid-clear reset and parameter sweep:** re-assert `rst` at cptr=10 → `ready` rises exactly DEPTH edges after the second release. Repeat all scenarios with DW=64, DEPTH=16, NRD=3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, write bypass, zero masking, stall hold.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  input  logic [DEPTH-1:0][DW-1:0]  regs,
  input  logic                      wr_acc,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DW-1:0]             wr_data,
  output logic [DW-1:0]             rd_data
);

  logic [DW-1:0] rd_data_d, rd_data_q;
  logic          hit;
  logic          zero_hit;

  assign hit      = (BYPASS != 0) && wr_acc && (wr_addr == rd_addr);
  assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (!run || zero_hit) rd_data_d = '0;
      else if (hit)         rd_data_d = wr_data;
      else                  rd_data_d = regs[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read/one-write register file with hardware clear after reset.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ReadAddr,
  input  logic [NRD-1:0]      ReadEn,
  output logic [NRD*DW-1:0]   ReadData,
  input  logic [AW-1:0]       WriteAddr,
  input  logic [DW-1:0]       WriteData,
  input  logic                WriteEnable,
  output logic                ready
);

  rf_state_t               state_d, state_q;
  logic [AW-1:0]           cptr_d, cptr_q;
  logic [DEPTH-1:0][DW-1:0] regs_d, regs_q;
  logic                    run;
  logic                    wr_acc;

  assign run    = (state_q == RUN);
  assign wr_acc = run && !rst && WriteEnable && !((ZERO_REG != 0) && (WriteAddr == '0));

  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    if (state_q == CLEAR) begin
      cptr_d = cptr_q + AW'(1);
      // cptr stops at DEPTH-1; the state change ends the sweep instead of a wrap
      if (cptr_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
        cptr_d  = cptr_q;
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (!rst) begin
      if (state_q == CLEAR) regs_d[cptr_q] = '0;
      else if (wr_acc)      regs_d[WriteAddr] = WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
    end
  end

  // Contents are meaningless until the clear sweep finishes, so no reset here.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign ready = run;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_read_port #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .rd_en   (ReadEn[k]),
      .rd_addr (ReadAddr[k*AW +: AW]),
      .regs    (regs_q),
      .wr_acc  (wr_acc),
      .wr_addr (WriteAddr),
      .wr_data (WriteData),
      .rd_data (ReadData[k*DW +: DW])
    );
  end

endmodule
